ac_motor_pwm_gate: RTL and testbench



---
 rtl/ac_motor_pkg.sv | 21 ++
 rtl/ac_motor_deadtime.sv | 93 +++++++++
 rtl/ac_motor_pwm_gate.sv | 90 +++++++++
 tb/tb_ac_motor_pwm_gate.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the AC motor bridge gate path.
// Latency: n/a (definitions only).
// Backpressure: none.
`timescale 1ns/1ps
package ac_motor_pkg;

    localparam int TRI_W_DEF = 25;

    localparam int PH_U = 0;
    localparam int PH_V = 1;
    localparam int PH_W = 2;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DEAD_HI,
        ST_HI,
        ST_DEAD_LO,
        ST_LO
    } phase_state_t;

endpackage

// File: rtl/ac_motor_deadtime.sv
// One bridge leg: complementary hi/lo gates with dead-time insertion.
// Latency: demand to gate change is DEAD_CYCLES+1 cycles; en low forces OFF on the next edge.
// Backpressure: none; demand pulses shorter than the dead interval are swallowed.
`timescale 1ns/1ps
module ac_motor_deadtime
    import ac_motor_pkg::*;
#(
    parameter int DEAD_CYCLES = 20,
    parameter int DEAD_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic demand,
    output logic hi,
    output logic lo
);

    localparam logic [DEAD_W-1:0] RELOAD = DEAD_W'(DEAD_CYCLES - 1);

    phase_state_t      state;
    phase_state_t      state_nxt;
    logic [DEAD_W-1:0] cnt;
    logic [DEAD_W-1:0] cnt_nxt;

    // Gates are registered copies of the next-state decode so they toggle with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
            cnt   <= '0;
            hi    <= 1'b0;
            lo    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= (state_nxt == ST_HI);
            lo    <= (state_nxt == ST_LO);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!en) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_nxt = demand ? ST_DEAD_HI : ST_DEAD_LO;
                    cnt_nxt   = RELOAD;
                end
                ST_DEAD_HI: begin
                    if (!demand) begin
                        state_nxt = ST_DEAD_LO;
                        cnt_nxt   = RELOAD;
                    end else if (cnt == '0) begin
                        state_nxt = ST_HI;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_HI: begin
                    if (!demand) begin
                        state_nxt = ST_DEAD_LO;
                        cnt_nxt   = RELOAD;
                    end
                end
                ST_DEAD_LO: begin
                    if (demand) begin
                        state_nxt = ST_DEAD_HI;
                        cnt_nxt   = RELOAD;
                    end else if (cnt == '0) begin
                        state_nxt = ST_LO;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_LO: begin
                    if (demand) begin
                        state_nxt = ST_DEAD_HI;
                        cnt_nxt   = RELOAD;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ac_motor_pwm_gate.sv
// Three-phase bridge gate generator: valley-synced shadow refs, carrier compare, dead-time legs.
// Latency: carrier sample to demand 1 cycle, demand to gate DEAD_CYCLES+1 cycles.
// Backpressure: none; references are only sampled at the carrier valley while enabled.
`timescale 1ns/1ps
module ac_motor_pwm_gate
    import ac_motor_pkg::*;
#(
    parameter int TRI_W       = TRI_W_DEF,
    parameter int DEAD_CYCLES = 20,
    parameter int DEAD_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TRI_W-1:0] triangle,
    input  logic             cw,
    input  logic             ccw,
    input  logic             lock,
    input  logic [TRI_W-1:0] ref_u,
    input  logic [TRI_W-1:0] ref_v,
    input  logic [TRI_W-1:0] ref_w,
    output logic [2:0]       gate_hi,
    output logic [2:0]       gate_lo,
    output logic             pwm_sync,
    output logic             active
);

    logic                  en;
    logic                  en_q;
    logic                  swap;
    logic                  valley;
    logic                  slope_rising;
    logic [TRI_W-1:0]      tri_prev;
    logic [2:0][TRI_W-1:0] map_ref;
    logic [2:0][TRI_W-1:0] shadow;
    logic [2:0]            demand;

    assign en     = lock & (cw ^ ccw);
    assign swap   = ccw & ~cw;
    assign valley = ~slope_rising & ($signed(triangle) > $signed(tri_prev));
    assign active = en_q;

    // Counter-clockwise rotation is produced by exchanging the V and W legs.
    always_comb begin
        map_ref[PH_U] = ref_u;
        map_ref[PH_V] = swap ? ref_w : ref_v;
        map_ref[PH_W] = swap ? ref_v : ref_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            tri_prev     <= '0;
            slope_rising <= 1'b0;
            shadow       <= '0;
            pwm_sync     <= 1'b0;
            demand       <= '0;
        end else begin
            en_q     <= en;
            tri_prev <= triangle;
            if (valley) begin
                slope_rising <= 1'b1;
            end else if ($signed(triangle) < $signed(tri_prev)) begin
                slope_rising <= 1'b0;
            end
            // Shadows track the refs freely while idle so the first enabled period starts fresh.
            if (!en_q || valley) begin
                shadow <= map_ref;
            end
            pwm_sync <= valley & en_q;
            for (int i = 0; i < 3; i++) begin
                demand[i] <= ($signed(shadow[i]) > $signed(triangle));
            end
        end
    end

    for (genvar ph = 0; ph < 3; ph++) begin : g_leg
        ac_motor_deadtime #(
            .DEAD_CYCLES (DEAD_CYCLES),
            .DEAD_W      (DEAD_W)
        ) u_deadtime (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .demand (demand[ph]),
            .hi     (gate_hi[ph]),
            .lo     (gate_lo[ph])
        );
    end

endmodule

// File: tb/tb_ac_motor_pwm_gate.sv
// Directed bench for ac_motor_pwm_gate: 400-cycle triangle carrier, duty and dead-time checks.
`timescale 1ns/1ps
module tb_ac_motor_pwm_gate;

    localparam int TRI_W = 25;
    localparam int DEAD  = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [TRI_W-1:0] triangle;
    logic             cw;
    logic             ccw;
    logic             lock;
    logic [TRI_W-1:0] ref_u;
    logic [TRI_W-1:0] ref_v;
    logic [TRI_W-1:0] ref_w;
    logic [2:0]       gate_hi;
    logic [2:0]       gate_lo;
    logic             pwm_sync;
    logic             active;

    int n_cmp = 0;
    int n_bad = 0;
    int p;
    int last_p;
    int n_step = 0;
    int hi_cnt[3];
    int lo_cnt[3];
    int zero_cnt[3];
    int hi_fall[3];
    int lo_fall[3];
    int sync_cnt;
    int sync_at;
    int overlap_cnt = 0;
    int gap_viol = 0;
    logic [2:0] prev_hi = 3'b000;
    logic [2:0] prev_lo = 3'b000;

    ac_motor_pwm_gate #(
        .TRI_W       (TRI_W),
        .DEAD_CYCLES (DEAD),
        .DEAD_W      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .triangle (triangle),
        .cw       (cw),
        .ccw      (ccw),
        .lock     (lock),
        .ref_u    (ref_u),
        .ref_v    (ref_v),
        .ref_w    (ref_w),
        .gate_hi  (gate_hi),
        .gate_lo  (gate_lo),
        .pwm_sync (pwm_sync),
        .active   (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Carrier phase 0..399: rising -1000..990, then falling 1000..-990.
    function automatic logic [TRI_W-1:0] tri_at(input int ph);
        int v;
        v = (ph < 200) ? (-1000 + 10 * ph) : (1000 - 10 * (ph - 200));
        return TRI_W'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        n_step++;
        last_p = p;
        for (int i = 0; i < 3; i++) begin
            if (gate_hi[i] && gate_lo[i]) overlap_cnt++;
            if (prev_hi[i] && !gate_hi[i]) hi_fall[i] = n_step;
            if (prev_lo[i] && !gate_lo[i]) lo_fall[i] = n_step;
            if (!prev_hi[i] && gate_hi[i] && (n_step - lo_fall[i] < DEAD)) gap_viol++;
            if (!prev_lo[i] && gate_lo[i] && (n_step - hi_fall[i] < DEAD)) gap_viol++;
            hi_cnt[i]   += int'(gate_hi[i]);
            lo_cnt[i]   += int'(gate_lo[i]);
            zero_cnt[i] += int'(!gate_hi[i] && !gate_lo[i]);
        end
        if (pwm_sync) begin
            sync_cnt++;
            sync_at = last_p;
        end
        prev_hi  = gate_hi;
        prev_lo  = gate_lo;
        p        = (p + 1) % 400;
        triangle = tri_at(p);
    endtask

    task automatic measure(input int n);
        for (int i = 0; i < 3; i++) begin
            hi_cnt[i]   = 0;
            lo_cnt[i]   = 0;
            zero_cnt[i] = 0;
        end
        sync_cnt = 0;
        sync_at  = -1;
        repeat (n) step();
    endtask

    task automatic wait_p(input int x);
        while (p != x) step();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            hi_fall[i] = -1000;
            lo_fall[i] = -1000;
        end
        rst_n    = 1'b0;
        lock     = 1'b1;
        cw       = 1'b1;
        ccw      = 1'b0;
        ref_u    = TRI_W'(0);
        ref_v    = TRI_W'(500);
        ref_w    = TRI_W'(-500);
        p        = 0;
        triangle = tri_at(0);
        #2;
        check("rst_gate_hi", gate_hi, 0);
        check("rst_gate_lo", gate_lo, 0);
        check("rst_pwm_sync", pwm_sync, 0);
        check("rst_active", active, 0);
        step();
        step();
        rst_n = 1'b1;

        // Basic duty: U=0, V=500, W=-500, clockwise.
        repeat (800) step();
        wait_p(0);
        measure(400);
        check("t1_u_hi", hi_cnt[0], 179);
        check("t1_u_lo", lo_cnt[0], 181);
        check("t1_u_dead", zero_cnt[0], 40);
        check("t1_v_hi", hi_cnt[1], 279);
        check("t1_v_lo", lo_cnt[1], 81);
        check("t1_w_hi", hi_cnt[2], 79);
        check("t1_w_lo", lo_cnt[2], 281);
        check("t1_sync_cnt", sync_cnt, 1);
        check("t1_sync_at", sync_at, 1);
        check("t1_active", active, 1);

        // Mid-slope reference change must wait for the next valley.
        wait_p(100);
        ref_u = TRI_W'(800);
        step();
        measure(299);
        check("t2_old_u_hi", hi_cnt[0], 78);
        check("t2_old_u_lo", lo_cnt[0], 181);
        check("t2_no_sync", sync_cnt, 0);
        measure(400);
        check("t2_new_u_hi", hi_cnt[0], 339);
        check("t2_new_u_lo", lo_cnt[0], 21);
        check("t2_sync_cnt", sync_cnt, 1);
        check("t2_sync_at", sync_at, 1);

        // Counter-clockwise swaps V and W legs.
        ref_u = TRI_W'(0);
        cw    = 1'b0;
        ccw   = 1'b1;
        repeat (800) step();
        wait_p(0);
        measure(400);
        check("t3_ph0_hi", hi_cnt[0], 179);
        check("t3_ph0_lo", lo_cnt[0], 181);
        check("t3_ph1_hi", hi_cnt[1], 79);
        check("t3_ph1_lo", lo_cnt[1], 281);
        check("t3_ph2_hi", hi_cnt[2], 279);
        check("t3_ph2_lo", lo_cnt[2], 81);

        // Lock loss and recovery.
        wait_p(20);
        check("t4_pre_hi", gate_hi, 7);
        lock = 1'b0;
        step();
        check("t4_off_hi", gate_hi, 0);
        check("t4_off_lo", gate_lo, 0);
        check("t4_off_active", active, 0);
        repeat (4) step();
        lock = 1'b1;
        measure(20);
        check("t4_dead_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2], 0);
        check("t4_dead_lo", lo_cnt[0] + lo_cnt[1] + lo_cnt[2], 0);
        step();
        check("t4_resume_hi", gate_hi, 7);
        check("t4_resume_lo", gate_lo, 0);
        check("t4_resume_active", active, 1);

        // Conflicting direction disables the bridge; then full-scale refs.
        cw  = 1'b1;
        ccw = 1'b1;
        step();
        check("t5_off_hi", gate_hi, 0);
        check("t5_off_lo", gate_lo, 0);
        check("t5_off_active", active, 0);
        ref_u = TRI_W'(1010);
        measure(400);
        check("t5_idle_gates", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + lo_cnt[0] + lo_cnt[1] + lo_cnt[2], 0);
        check("t5_idle_sync", sync_cnt, 0);
        ccw = 1'b0;
        repeat (800) step();
        measure(400);
        check("t5_full_hi", hi_cnt[0], 400);
        check("t5_full_hi_lo", lo_cnt[0], 0);
        ref_u = TRI_W'(-1000);
        repeat (800) step();
        measure(400);
        check("t5_zero_lo", lo_cnt[0], 400);
        check("t5_zero_hi", hi_cnt[0], 0);

        // Asynchronous reset while gates are driven.
        ref_u = TRI_W'(0);
        repeat (800) step();
        wait_p(20);
        check("t6_pre_hi", gate_hi, 7);
        rst_n = 1'b0;
        #1;
        check("t6_async_hi", gate_hi, 0);
        check("t6_async_lo", gate_lo, 0);
        repeat (3) step();
        check("t6_rst_hi", gate_hi, 0);
        check("t6_rst_lo", gate_lo, 0);
        check("t6_rst_sync", pwm_sync, 0);
        check("t6_rst_active", active, 0);
        rst_n = 1'b1;
        measure(20);
        check("t6_dead_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2], 0);
        check("t6_dead_lo", lo_cnt[0] + lo_cnt[1] + lo_cnt[2], 0);
        step();
        check("t6_dead_tail", gate_hi, 0);
        step();
        check("t6_resume_hi", gate_hi, 7);
        check("t6_active", active, 1);

        check("no_shoot_through", overlap_cnt, 0);
        check("dead_gap", gap_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
